// File: rtl/digit_set_ctrl_pkg.sv
// digit_set_ctrl_pkg: shared state encoding and timeout counter sizing
package digit_set_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EDIT   = 2'd2,
    COMMIT = 2'd3
  } state_t;
  localparam int TO_CYC_DEF = 1000;
  function automatic int cnt_width(input int to_cyc);
    return (to_cyc < 2) ? 1 : $clog2(to_cyc);
  endfunction
endpackage

// File: rtl/digit_set_ctrl_if.sv
// digit_set_ctrl_if: button, live-value and write-back bundle of the digit editor
interface digit_set_ctrl_if;
  logic        btn_mode;
  logic        btn_next;
  logic        btn_up;
  logic        btn_dn;
  logic [15:0] cur_val;
  logic [3:0]  wr_data;
  logic [3:0]  wr_en;
  logic [15:0] shadow;
  logic [1:0]  cursor;
  logic        editing;
  logic        done;
  logic        abort;
  modport master (
    output btn_mode, btn_next, btn_up, btn_dn, cur_val,
    input  wr_data, wr_en, shadow, cursor, editing, done, abort
  );
  modport slave (
    input  btn_mode, btn_next, btn_up, btn_dn, cur_val,
    output wr_data, wr_en, shadow, cursor, editing, done, abort
  );
endinterface

// File: rtl/digit_set_ctrl_wrap.sv
// digit_wrap_step: one increment/decrement of a digit wrapping within 0..mx
module digit_wrap_step (
  input  logic [3:0] digit,
  input  logic [3:0] mx,
  input  logic       up,
  input  logic       dn,
  output logic [3:0] nxt
);
  assign nxt = up ? ((digit >= mx) ? 4'd0 : digit + 4'd1) :
               dn ? ((digit == 4'd0) ? mx : digit - 4'd1) : digit;
endmodule

// File: rtl/digit_set_ctrl.sv
// digit_set_ctrl: edit a shadow copy of four digit registers and write it back one digit per cycle
module digit_set_ctrl
  import digit_set_ctrl_pkg::*;
#(
  parameter int MAX0   = 9,
  parameter int MAX1   = 5,
  parameter int MAX2   = 9,
  parameter int MAX3   = 5,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input logic           clk,
  input logic           rst,
  digit_set_ctrl_if.slave bus
);
  localparam int CW = cnt_width(TO_CYC);
  localparam logic [15:0] MAXV = {4'(MAX3), 4'(MAX2), 4'(MAX1), 4'(MAX0)};
  state_t        state_q, state_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [1:0]    cursor_q, cursor_d, k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    wr_en_q, wr_en_d, wr_data_q, wr_data_d, step;
  logic          editing_q, editing_d, done_q, done_d, abort_q, abort_d;
  logic          any_btn, up_act, dn_act;
  assign any_btn = bus.btn_mode | bus.btn_next | bus.btn_up | bus.btn_dn;
  assign up_act  = bus.btn_up & ~bus.btn_mode & ~bus.btn_next;
  assign dn_act  = bus.btn_dn & ~bus.btn_mode & ~bus.btn_next & ~bus.btn_up;
  digit_wrap_step u_step (
    .digit(shadow_q[{cursor_q, 2'b00} +: 4]),
    .mx   (MAXV[{cursor_q, 2'b00} +: 4]),
    .up   (up_act),
    .dn   (dn_act),
    .nxt  (step)
  );
  // next-state, edit actions, and the registered output values they imply
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cursor_d = cursor_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      IDLE: state_d = bus.btn_mode ? LOAD : IDLE;
      LOAD: begin
        for (int i = 0; i < 4; i++)
          shadow_d[4*i +: 4] = (bus.cur_val[4*i +: 4] > MAXV[4*i +: 4]) ? 4'd0 : bus.cur_val[4*i +: 4];
        cursor_d = 2'd0;
        cnt_d    = '0;
        state_d  = EDIT;
      end
      EDIT: begin
        cnt_d = any_btn ? '0 : cnt_q + CW'(1);
        if (bus.btn_mode) begin
          state_d = COMMIT;
          k_d     = 2'd0;
        end else if (bus.btn_next) cursor_d = cursor_q + 2'd1;
        else if (any_btn) shadow_d[{cursor_q, 2'b00} +: 4] = step;
        else if (cnt_q == CW'(TO_CYC - 1)) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end
      end
      COMMIT: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
    wr_en_d   = (state_d == COMMIT) ? 4'b0001 << k_d : 4'b0000;
    wr_data_d = (state_d == COMMIT) ? shadow_d[{k_d, 2'b00} +: 4] : 4'd0;
    editing_d = (state_d == LOAD) || (state_d == EDIT);
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      cursor_q  <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      editing_q <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      cursor_q  <= cursor_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      editing_q <= editing_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end
  assign bus.wr_data = wr_data_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.shadow  = shadow_q;
  assign bus.cursor  = cursor_q;
  assign bus.editing = editing_q;
  assign bus.done    = done_q;
  assign bus.abort   = abort_q;
endmodule

// File: tb/tb_digit_set_ctrl.sv
// tb_digit_set_ctrl: directed and random checks of digit_set_ctrl against a digit-list model
module tb_digit_set_ctrl;
  localparam int TO = 8;
  localparam int MX[4] = '{9, 5, 9, 5};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  digit_set_ctrl_if bus ();
  digit_set_ctrl #(.TO_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  int ms, mc, mi, mk;
  int md[4];
  logic [3:0] e_we, e_wd;
  logic e_done, e_abort;
  logic [28:0] dut_out;
  assign dut_out = {bus.wr_data, bus.wr_en, bus.shadow, bus.cursor, bus.editing, bus.done, bus.abort};

  function automatic logic [28:0] model_out();
    logic [15:0] sh;
    for (int i = 0; i < 4; i++) sh[4*i +: 4] = 4'(md[i]);
    return {e_wd, e_we, sh, 2'(mc), (ms == 1 || ms == 2), e_done, e_abort};
  endfunction

  task automatic model_reset();
    ms = 0; mc = 0; mi = 0; mk = 0;
    for (int i = 0; i < 4; i++) md[i] = 0;
    e_we = 0; e_wd = 0; e_done = 0; e_abort = 0;
  endtask

  task automatic model_step(input logic [3:0] b);
    e_done = 0; e_abort = 0; e_we = 0; e_wd = 0;
    if (ms == 0) begin
      if (b[3]) ms = 1;
    end else if (ms == 1) begin
      for (int i = 0; i < 4; i++) begin
        int d;
        d = int'(bus.cur_val[4*i +: 4]);
        md[i] = (d > MX[i]) ? 0 : d;
      end
      mc = 0; mi = 0; ms = 2;
    end else if (ms == 2) begin
      if (b[3]) begin
        ms = 3; mk = 0; e_we = 4'b0001; e_wd = 4'(md[0]);
      end else if (b[2]) mc = (mc + 1) % 4;
      else if (b[1]) md[mc] = (md[mc] + 1) % (MX[mc] + 1);
      else if (b[0]) md[mc] = (md[mc] + MX[mc]) % (MX[mc] + 1);
      if (b != 0) mi = 0;
      else if (mi == TO - 1) begin
        ms = 0; e_abort = 1;
      end else mi++;
    end else begin
      if (mk == 3) begin
        ms = 0; e_done = 1;
      end else begin
        mk++; e_we = 4'(1 << mk); e_wd = 4'(md[mk]);
      end
    end
  endtask

  task automatic cyc(input logic [3:0] b);
    {bus.btn_mode, bus.btn_next, bus.btn_up, bus.btn_dn} = b;
    @(posedge clk);
    model_step(b);
    @(negedge clk);
    {bus.btn_mode, bus.btn_next, bus.btn_up, bus.btn_dn} = 4'b0;
  endtask

  task automatic enter(input logic [15:0] v);
    bus.cur_val = v;
    cyc(4'b1000);
    cyc(4'b0000);
  endtask

  task automatic test_reset();
    {bus.btn_mode, bus.btn_next, bus.btn_up, bus.btn_dn} = 4'b0;
    bus.cur_val = 16'h0;
    model_reset();
    #2;
    n_chk++;
    if (dut_out !== 29'd0) begin n_fail++; $display("FAIL reset_state got=%h exp=0", dut_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_up_wrap();
    bus.cur_val = 16'h5959;
    cyc(4'b1000);
    n_chk++;
    if (bus.editing !== 1'b1) begin n_fail++; $display("FAIL load_editing got=%b exp=1", bus.editing); end
    cyc(4'b0000);
    n_chk++;
    if (bus.shadow !== 16'h5959 || bus.cursor !== 2'd0) begin n_fail++; $display("FAIL load_shadow got=%h/%0d exp=5959/0", bus.shadow, bus.cursor); end
    cyc(4'b0010);
    n_chk++;
    if (bus.shadow !== 16'h5950) begin n_fail++; $display("FAIL up_wrap9 got=%h exp=5950", bus.shadow); end
    cyc(4'b0100);
    cyc(4'b0010);
    n_chk++;
    if (bus.shadow !== 16'h5900 || dut_out !== model_out()) begin n_fail++; $display("FAIL up_wrap5 got=%h exp=5900 model=%h", dut_out, model_out()); end
    cyc(4'b1000);
    repeat (5) cyc(4'b0000);
  endtask

  task automatic test_clamp_dn();
    logic [3:0] seq [4] = '{4'd2, 4'd1, 4'd0, 4'd9};
    enter(16'hF0A3);
    n_chk++;
    if (bus.shadow !== 16'h0003) begin n_fail++; $display("FAIL clamp got=%h exp=0003", bus.shadow); end
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0001);
      n_chk++;
      if (bus.shadow[3:0] !== seq[i] || dut_out !== model_out()) begin n_fail++; $display("FAIL dn_step%0d got=%h exp_digit=%0d model=%h", i, dut_out, seq[i], model_out()); end
    end
    cyc(4'b1000);
    repeat (5) cyc(4'b0000);
  endtask

  task automatic test_commit();
    logic [3:0] we [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] wd [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
    enter(16'h1234);
    for (int i = 0; i < 4; i++) begin
      cyc(i == 0 ? 4'b1000 : 4'b0000);
      n_chk++;
      if (bus.wr_en !== we[i] || bus.wr_data !== wd[i] || bus.editing !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++; $display("FAIL commit%0d got=%b/%h/%b exp=%b/%h/0", i, bus.wr_en, bus.wr_data, bus.editing, we[i], wd[i]);
      end
    end
    cyc(4'b0000);
    n_chk++;
    if (bus.done !== 1'b1 || bus.wr_en !== 4'b0 || bus.editing !== 1'b0) begin n_fail++; $display("FAIL commit_done got=%b/%b exp=1/0000", bus.done, bus.wr_en); end
    cyc(4'b0000);
    n_chk++;
    if (bus.done !== 1'b0 || dut_out !== model_out()) begin n_fail++; $display("FAIL done_pulse got=%h exp=%h", dut_out, model_out()); end
  endtask

  task automatic test_timeout();
    enter(16'h0000);
    for (int i = 1; i <= 8; i++) begin
      cyc(4'b0000);
      n_chk++;
      if (bus.abort !== (i == 8) || bus.wr_en !== 4'b0 || dut_out !== model_out()) begin n_fail++; $display("FAIL timeout%0d got=%h exp_abort=%0d model=%h", i, dut_out, i == 8, model_out()); end
    end
    n_chk++;
    if (bus.editing !== 1'b0) begin n_fail++; $display("FAIL abort_editing got=%b exp=0", bus.editing); end
    cyc(4'b0000);
    enter(16'h0000);
    repeat (5) cyc(4'b0000);
    cyc(4'b0100);
    for (int i = 1; i <= 8; i++) begin
      cyc(4'b0000);
      n_chk++;
      if (bus.abort !== (i == 8) || bus.wr_en !== 4'b0 || dut_out !== model_out()) begin n_fail++; $display("FAIL timeout_next%0d got=%h exp_abort=%0d model=%h", i, dut_out, i == 8, model_out()); end
    end
    cyc(4'b0000);
  endtask

  task automatic test_priority();
    enter(16'h1357);
    cyc(4'b1010);
    n_chk++;
    if (bus.shadow !== 16'h1357 || bus.wr_en !== 4'b0001 || bus.editing !== 1'b0) begin n_fail++; $display("FAIL mode_up got=%h/%b exp=1357/0001", bus.shadow, bus.wr_en); end
    repeat (5) cyc(4'b0000);
    enter(16'h1357);
    cyc(4'b0101);
    n_chk++;
    if (bus.shadow !== 16'h1357 || bus.cursor !== 2'd1 || dut_out !== model_out()) begin n_fail++; $display("FAIL next_dn got=%h/%0d exp=1357/1", bus.shadow, bus.cursor); end
    cyc(4'b1000);
    repeat (5) cyc(4'b0000);
  endtask

  task automatic test_reset_mid_edit();
    enter(16'h3412);
    n_chk++;
    if (bus.shadow !== 16'h3412) begin n_fail++; $display("FAIL pre_reset got=%h exp=3412", bus.shadow); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_chk++;
    if (dut_out !== 29'd0) begin n_fail++; $display("FAIL async_reset got=%h exp=0", dut_out); end
    @(negedge clk);
    rst = 1'b0;
    cyc(4'b0010);
    n_chk++;
    if (bus.shadow !== 16'h0 || bus.editing !== 1'b0 || dut_out !== model_out()) begin n_fail++; $display("FAIL post_reset_idle got=%h exp=%h", dut_out, model_out()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic [3:0] b;
      b[3] = ($urandom_range(0, 9) == 0);
      b[2] = ($urandom_range(0, 4) == 0);
      b[1] = ($urandom_range(0, 3) == 0);
      b[0] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) b = 4'b0;
      bus.cur_val = 16'($urandom);
      cyc(b);
      n_chk++;
      if (dut_out !== model_out()) begin n_fail++; $display("FAIL random%0d got=%h exp=%h", i, dut_out, model_out()); end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_clamp_dn();
    test_commit();
    test_timeout();
    test_priority();
    test_reset_mid_edit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
